// File: rtl/ttt_pkg.sv
// Shared state encodings, win masks and screen limits for the tic-tac-toe board controller.
package ttt_pkg;

  typedef enum logic [2:0] {
    StPlay,
    StCheck,
    StXWon,
    StOWon,
    StDraw
  } state_e;

  typedef enum logic [1:0] {
    GsPlay = 2'd0,
    GsXWon = 2'd1,
    GsOWon = 2'd2,
    GsDraw = 2'd3
  } game_state_e;

  localparam int unsigned ScreenXMax = 1023;
  localparam int unsigned ScreenYMax = 767;

  localparam logic [8:0] FullBoard = 9'h1FF;

  // Index 0 is row 0; order is rows 0-2, columns 0-2, diagonal 0-4-8, diagonal 2-4-6.
  localparam logic [7:0][8:0] WIN_MASK = {
    9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
  };

  // Lowest-indexed complete line owned by `cells`, or zero when none is complete.
  function automatic logic [8:0] first_win(input logic [8:0] cells);
    logic [8:0] hit;
    hit = '0;
    for (int i = 7; i >= 0; i--) begin
      if ((cells & WIN_MASK[i]) == WIN_MASK[i]) hit = WIN_MASK[i];
    end
    return hit;
  endfunction

endpackage

// File: rtl/cell_decode.sv
// Registered mapping of a screen position onto a 3x3 grid cell index (row*3+col).
module cell_decode import ttt_pkg::*; #(
  parameter int unsigned COL1_START = 344,
  parameter int unsigned COL2_START = 680,
  parameter int unsigned ROW1_START = 252,
  parameter int unsigned ROW2_START = 516
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  output logic        valid_o,
  output logic [3:0]  idx_o
);

  logic [1:0] col, row;
  logic       valid_d, valid_q;
  logic [3:0] idx_d, idx_q;

  always_comb begin
    col = 2'd0;
    row = 2'd0;
    if (xpos_i >= 12'(COL2_START))      col = 2'd2;
    else if (xpos_i >= 12'(COL1_START)) col = 2'd1;
    if (ypos_i >= 12'(ROW2_START))      row = 2'd2;
    else if (ypos_i >= 12'(ROW1_START)) row = 2'd1;
    valid_d = (xpos_i <= 12'(ScreenXMax)) && (ypos_i <= 12'(ScreenYMax));
    idx_d   = ({2'b00, row} * 4'd3) + {2'b00, col};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_o = valid_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/board_ctl.sv
// Tic-tac-toe game-state controller: click capture, move recording, win/draw detection.
// Optional per-move timeout enabled by defining BOARD_CTL_TURN_TIMEOUT_EN.
module board_ctl import ttt_pkg::*; #(
  parameter int unsigned COL1_START     = 344,
  parameter int unsigned COL2_START     = 680,
  parameter int unsigned ROW1_START     = 252,
  parameter int unsigned ROW2_START     = 516,
  parameter int unsigned TIMEOUT_CYCLES = 650_000_000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        new_game,
  output logic [8:0]  square,
  output logic [8:0]  cell_x,
  output logic [8:0]  cell_o,
  output logic        turn_o,
  output logic [1:0]  game_state
);

  state_e      state_q, state_d;
  game_state_e gs_q, gs_d;
  logic [8:0]  cell_x_q, cell_x_d, cell_o_q, cell_o_d, square_q, square_d;
  logic        turn_q, turn_d;
  logic        ml_q, click_q, click_d;
  logic        dec_valid;
  logic [3:0]  dec_idx;
  logic [8:0]  dec_onehot, occupied, mover, line;
  logic        move_ok, tmo_hit;

  cell_decode #(
    .COL1_START(COL1_START),
    .COL2_START(COL2_START),
    .ROW1_START(ROW1_START),
    .ROW2_START(ROW2_START)
  ) u_cell_decode (
    .clk_i  (pclk),
    .rst_ni (rst),
    .xpos_i (xpos),
    .ypos_i (ypos),
    .valid_o(dec_valid),
    .idx_o  (dec_idx)
  );

  // A pending click is killed by new_game so it cannot land on the freshly cleared board.
  assign click_d    = mouse_left & ~ml_q & ~new_game;
  assign dec_onehot = dec_valid ? (9'b1 << dec_idx) : 9'b0;
  assign occupied   = cell_x_q | cell_o_q;
  assign move_ok    = (state_q == StPlay) && click_q && ((dec_onehot & ~occupied) != 9'b0);
  assign mover      = turn_q ? cell_o_q : cell_x_q;
  assign line       = first_win(mover);

`ifdef BOARD_CTL_TURN_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if ((state_q == StPlay) && !new_game && !move_ok) begin
      if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
      else                                  tmo_d   = tmo_q + 32'd1;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    gs_d     = gs_q;
    cell_x_d = cell_x_q;
    cell_o_d = cell_o_q;
    turn_d   = turn_q;
    square_d = '0;
    if (new_game) begin
      state_d  = StPlay;
      gs_d     = GsPlay;
      cell_x_d = '0;
      cell_o_d = '0;
      turn_d   = 1'b0;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (move_ok) begin
            if (turn_q) cell_o_d = cell_o_q | dec_onehot;
            else        cell_x_d = cell_x_q | dec_onehot;
            state_d = StCheck;
          end else if (tmo_hit) begin
            turn_d = ~turn_q;
          end
        end
        StCheck: begin
          // A completed line outranks a full board, so a ninth-move win is a win.
          if (line != 9'b0) begin
            state_d = turn_q ? StOWon : StXWon;
            gs_d    = turn_q ? GsOWon : GsXWon;
          end else if (occupied == FullBoard) begin
            state_d = StDraw;
            gs_d    = GsDraw;
          end else begin
            turn_d  = ~turn_q;
            state_d = StPlay;
          end
        end
        default: ;
      endcase
    end

    unique case (state_d)
      StPlay:         square_d = dec_onehot & ~(cell_x_d | cell_o_d);
      StXWon:         square_d = first_win(cell_x_d);
      StOWon:         square_d = first_win(cell_o_d);
      default:        square_d = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= StPlay;
      gs_q     <= GsPlay;
      cell_x_q <= '0;
      cell_o_q <= '0;
      square_q <= '0;
      turn_q   <= 1'b0;
      ml_q     <= 1'b0;
      click_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gs_q     <= gs_d;
      cell_x_q <= cell_x_d;
      cell_o_q <= cell_o_d;
      square_q <= square_d;
      turn_q   <= turn_d;
      ml_q     <= mouse_left;
      click_q  <= click_d;
    end
  end

  assign square     = square_q;
  assign cell_x     = cell_x_q;
  assign cell_o     = cell_o_q;
  assign turn_o     = turn_q;
  assign game_state = gs_q;

endmodule

// File: tb/tb_board_ctl.sv
// Self-checking bench for board_ctl: directed game scenarios plus random play against a
// board-level reference model of the game rules.
module tb_board_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        mouse_left = 1'b0;
  logic        new_game = 1'b0;
  logic [8:0]  square, cell_x, cell_o;
  logic        turn_o;
  logic [1:0]  game_state;

  int checks = 0;
  int failures = 0;

  // Reference model: board[i] 0 empty, 1 X, 2 O; m_turn 0 X / 1 O; m_gs as game_state.
  int board[9];
  int m_turn, m_gs;
  int cur_x, cur_y;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8},
                      '{0,4,8}, '{2,4,6}};
  int cxs[3] = '{100, 400, 800};
  int cys[3] = '{100, 350, 600};
  int bx[8] = '{0, 343, 344, 679, 680, 1023, 1024, 4095};
  int by[8] = '{0, 251, 252, 515, 516, 767, 768, 4095};

  board_ctl dut (
    .pclk      (pclk),
    .rst       (rst),
    .xpos      (xpos),
    .ypos      (ypos),
    .mouse_left(mouse_left),
    .new_game  (new_game),
    .square    (square),
    .cell_x    (cell_x),
    .cell_o    (cell_o),
    .turn_o    (turn_o),
    .game_state(game_state)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_idx(input int x, input int y);
    int col, row;
    if (x > 1023 || y > 767) return -1;
    col = (x < 344) ? 0 : (x < 680) ? 1 : 2;
    row = (y < 252) ? 0 : (y < 516) ? 1 : 2;
    return row * 3 + col;
  endfunction

  function automatic logic [8:0] model_win(input int p);
    logic [8:0] m;
    for (int l = 0; l < 8; l++) begin
      if (board[lines[l][0]] == p && board[lines[l][1]] == p && board[lines[l][2]] == p) begin
        m = '0;
        for (int k = 0; k < 3; k++) m[lines[l][k]] = 1'b1;
        return m;
      end
    end
    return 9'h000;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) board[i] = 0;
    m_turn = 0;
    m_gs = 0;
  endfunction

  task automatic set_pos(input int x, input int y);
    cur_x = x;
    cur_y = y;
    xpos = 12'(x);
    ypos = 12'(y);
  endtask

  task automatic chk_all(input string tag);
    logic [8:0] ex, eo, esq;
    int idx, full;
    ex = '0;
    eo = '0;
    for (int i = 0; i < 9; i++) begin
      if (board[i] == 1) ex[i] = 1'b1;
      if (board[i] == 2) eo[i] = 1'b1;
    end
    esq = '0;
    if (m_gs == 0) begin
      idx = model_idx(cur_x, cur_y);
      if (idx >= 0 && board[idx] == 0) esq[idx] = 1'b1;
    end else if (m_gs == 1) esq = model_win(1);
    else if (m_gs == 2) esq = model_win(2);
    full = 0;
    chk({tag, ".cell_x"}, 32'(cell_x), 32'(ex));
    chk({tag, ".cell_o"}, 32'(cell_o), 32'(eo));
    chk({tag, ".turn"}, 32'(turn_o), 32'(m_turn));
    chk({tag, ".state"}, 32'(game_state), 32'(m_gs));
    chk({tag, ".square"}, 32'(square), 32'(esq));
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    step();
    model_reset();
  endtask

  // Press at (x,y) for `hold` cycles, release, let the move settle, update model, compare.
  task automatic click_at(input int x, input int y, input int hold, input string tag);
    int idx, mover;
    set_pos(x, y);
    mouse_left = 1'b1;
    repeat (hold) step();
    mouse_left = 1'b0;
    repeat (4) step();
    idx = model_idx(x, y);
    if (m_gs == 0 && idx >= 0 && board[idx] == 0) begin
      mover = m_turn + 1;
      board[idx] = mover;
      if (model_win(mover) != 9'h000) m_gs = mover;
      else begin
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) if (board[i] != 0) n++;
        if (n == 9) m_gs = 3;
        else m_turn = 1 - m_turn;
      end
    end
    chk_all(tag);
  endtask

  task automatic click_cell(input int n, input string tag);
    click_at(cxs[n % 3], cys[n / 3], 2, tag);
  endtask

  initial begin
    int xs[5];
    int os[4];
    int dx[9];
    model_reset();
    set_pos(400, 100);
    repeat (3) step();
    chk("reset.square", 32'(square), 32'h0);
    chk("reset.state", 32'(game_state), 32'h0);
    rst = 1'b1;

    // Hover latency: decode then register.
    step();
    chk("hover.lat1", 32'(square), 32'h000);
    step();
    chk("hover.lat2", 32'(square), 32'h002);
    chk_all("hover");

    // Click latency and one move per held press.
    mouse_left = 1'b1;
    step();
    chk("click.lat1.cell_x", 32'(cell_x), 32'h000);
    step();
    chk("click.lat2.cell_x", 32'(cell_x), 32'h002);
    chk("click.lat2.turn", 32'(turn_o), 32'h0);
    step();
    chk("click.lat3.turn", 32'(turn_o), 32'h1);
    repeat (97) step();
    mouse_left = 1'b0;
    repeat (3) step();
    board[1] = 1;
    m_turn = 1;
    chk_all("click.held");

    // Boundary hover positions on an empty board.
    do_new_game();
    for (int i = 0; i < 8; i++) begin
      set_pos(bx[i], by[7 - i]);
      repeat (2) step();
      chk_all($sformatf("bound%0d", i));
      set_pos(bx[i], by[i]);
      repeat (2) step();
      chk_all($sformatf("boundd%0d", i));
    end

    // X wins on row 0; board then frozen.
    do_new_game();
    xs = '{0, 1, 2, 0, 0};
    os = '{3, 4, 0, 0};
    for (int k = 0; k < 5; k++) begin
      click_cell(xs[k / 2 * 0 + (k == 0 ? 0 : (k == 2 ? 1 : 2))], "winx.x");
      if (k == 2) break;
      click_cell(os[k], "winx.o");
    end
    chk("winx.state", 32'(game_state), 32'h1);
    chk("winx.square", 32'(square), 32'h007);
    click_cell(5, "winx.frozen");
    chk("winx.cell_o", 32'(cell_o), 32'h018);

    // Draw: X 0,2,3,7,8 / O 1,4,5,6.
    do_new_game();
    dx = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    for (int k = 0; k < 9; k++) click_cell(dx[k], $sformatf("draw%0d", k));
    chk("draw.state", 32'(game_state), 32'h3);
    chk("draw.square", 32'(square), 32'h000);

    // new_game coinciding with a click (edge-detect cycle, then write cycle).
    for (int d = 0; d < 2; d++) begin
      do_new_game();
      click_cell(4, "ng.pre");
      set_pos(cxs[0], cys[2]);
      mouse_left = 1'b1;
      repeat (d) step();
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      step();
      mouse_left = 1'b0;
      repeat (4) step();
      model_reset();
      chk_all($sformatf("ng.click%0d", d));
    end

    // Asynchronous reset mid-game.
    click_cell(0, "ar.pre0");
    click_cell(8, "ar.pre1");
    #3;
    rst = 1'b0;
    #1;
    chk("ar.square", 32'(square), 32'h0);
    chk("ar.cell_x", 32'(cell_x), 32'h0);
    chk("ar.cell_o", 32'(cell_o), 32'h0);
    chk("ar.turn", 32'(turn_o), 32'h0);
    chk("ar.state", 32'(game_state), 32'h0);
    #2;
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    chk_all("ar.post");

    // Random games, including off-grid and off-screen clicks.
    for (int g = 0; g < 20; g++) begin
      do_new_game();
      for (int k = 0; k < 14; k++) begin
        if ($urandom_range(0, 4) == 0)
          click_at($urandom_range(0, 1100), $urandom_range(0, 820), $urandom_range(1, 4),
                   $sformatf("rnd%0d.%0d", g, k));
        else
          click_at(cxs[$urandom_range(0, 2)] + $urandom_range(0, 200),
                   cys[$urandom_range(0, 2)] + $urandom_range(0, 150),
                   $urandom_range(1, 4), $sformatf("rnd%0d.%0d", g, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
